// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl
// User I/O sequencer for the 4-switch / 4-LED path.
// - Raw SW[3:0] and MODE_BTN are synchronised and debounced.
// - The debounced button steps through four LED mapping modes.
// - LED_USER shows a blink code of MODE+1 pulses.
// All state is on the rising edge of CLK, with a synchronous active-high RST.
module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16000,
  parameter int unsigned STEP_CYCLES     = 4000000,
  parameter int unsigned PULSE_CYCLES    = 2000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SW,
  input  logic       MODE_BTN,
  output logic [3:0] LED_BUS,
  output logic [1:0] MODE,
  output logic       LED_USER
);

  // Counter widths. Each width holds the terminal value of its counter.
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned PH_W   = $clog2(4 * PULSE_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PH_W-1:0]   GAP_LAST   = PH_W'(4 * PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0]   PULSE_LAST = PH_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    BL_GAP = 2'd0,
    BL_ON  = 2'd1,
    BL_OFF = 2'd2
  } blink_state_e;

  // True when exactly one bit of a 4-bit pattern is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Bit 4 carries MODE_BTN; bits 3:0 carry SW.
  logic [4:0]            sync1_q;
  logic [4:0]            sync2_q;
  logic [4:0]            deb_q;
  logic [4:0]            deb_d;
  logic [4:0][DB_W-1:0]  deb_cnt_q;
  logic [4:0][DB_W-1:0]  deb_cnt_d;

  logic                  btn_prev_q;
  logic                  mode_step_s;
  logic [1:0]            mode_q;
  logic [1:0]            mode_d;

  logic [3:0]            chase_q;
  logic [3:0]            chase_d;
  logic [STEP_W-1:0]     step_cnt_q;
  logic [STEP_W-1:0]     step_cnt_d;

  logic [3:0]            led_bus_q;
  logic [3:0]            led_bus_d;
  logic [3:0]            sw_db_s;

  blink_state_e          blink_state_q;
  logic [PH_W-1:0]       ph_cnt_q;
  logic [2:0]            pulse_cnt_q;
  logic [2:0]            pulse_target_s;
  logic                  led_user_q;

  assign sw_db_s = deb_q[3:0];

  // Debounce. A bit only follows its synced input after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement. Any agreement clears the counter.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DB_LAST) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Mode advance. Only the rising edge of the debounced button counts,
  // so holding the button steps MODE exactly once.
  always_comb begin
    mode_step_s = deb_q[4] & ~btn_prev_q;
    if (mode_step_s) begin
      mode_d = mode_q + 2'd1;
    end else begin
      mode_d = mode_q;
    end
  end

  // Chase pattern. It is held at 0001 outside mode 3, so entering mode 3
  // always starts from 0001 with a zero step counter. d[1] freezes the
  // chase and d[0] selects the rotate direction.
  always_comb begin
    chase_d    = chase_q;
    step_cnt_d = step_cnt_q;
    if (mode_q != 2'd3) begin
      chase_d    = 4'b0001;
      step_cnt_d = '0;
    end else if (!is_onehot4(chase_q)) begin
      chase_d    = 4'b0001;
      step_cnt_d = '0;
    end else if (sw_db_s[1]) begin
      chase_d    = chase_q;
      step_cnt_d = step_cnt_q;
    end else if (step_cnt_q == STEP_LAST) begin
      step_cnt_d = '0;
      if (sw_db_s[0]) begin
        chase_d = {chase_q[0], chase_q[3:1]};
      end else begin
        chase_d = {chase_q[2:0], chase_q[3]};
      end
    end else begin
      step_cnt_d = step_cnt_q + STEP_W'(1);
    end
  end

  // LED mapping. It uses the next MODE so that LED_BUS and MODE update on
  // the same edge. It uses the current debounced switches.
  always_comb begin
    case (mode_d)
      2'd0:    led_bus_d = sw_db_s;
      2'd1:    led_bus_d = {sw_db_s[3], ^sw_db_s, &sw_db_s, |sw_db_s};
      2'd2:    led_bus_d = {sw_db_s[0], sw_db_s[1], sw_db_s[2], sw_db_s[3]};
      2'd3:    led_bus_d = chase_d;
      default: led_bus_d = 4'b0000;
    endcase
  end

  // State registers for the synchronisers, debounce, mode, chase and LED bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= 5'd0;
      sync2_q    <= 5'd0;
      deb_q      <= 5'd0;
      deb_cnt_q  <= '0;
      btn_prev_q <= 1'b0;
      mode_q     <= 2'd0;
      chase_q    <= 4'b0001;
      step_cnt_q <= '0;
      led_bus_q  <= 4'b0000;
    end else begin
      sync1_q    <= {MODE_BTN, SW};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      btn_prev_q <= deb_q[4];
      mode_q     <= mode_d;
      chase_q    <= chase_d;
      step_cnt_q <= step_cnt_d;
      led_bus_q  <= led_bus_d;
    end
  end

  assign pulse_target_s = {1'b0, mode_q} + 3'd1;

  // Blink FSM. Cycle: GAP (4 pulse lengths low), then MODE+1 ON/OFF pulses.
  // A mode step restarts it from GAP on the edge where MODE updates, so an
  // old code never runs into a new one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_state_q <= BL_GAP;
      ph_cnt_q      <= '0;
      pulse_cnt_q   <= 3'd0;
      led_user_q    <= 1'b0;
    end else if (mode_step_s) begin
      blink_state_q <= BL_GAP;
      ph_cnt_q      <= '0;
      pulse_cnt_q   <= 3'd0;
      led_user_q    <= 1'b0;
    end else begin
      case (blink_state_q)
        BL_GAP: begin
          if (ph_cnt_q == GAP_LAST) begin
            blink_state_q <= BL_ON;
            ph_cnt_q      <= '0;
            pulse_cnt_q   <= 3'd0;
            led_user_q    <= 1'b1;
          end else begin
            ph_cnt_q      <= ph_cnt_q + PH_W'(1);
            led_user_q    <= 1'b0;
          end
        end
        BL_ON: begin
          if (ph_cnt_q == PULSE_LAST) begin
            blink_state_q <= BL_OFF;
            ph_cnt_q      <= '0;
            pulse_cnt_q   <= pulse_cnt_q + 3'd1;
            led_user_q    <= 1'b0;
          end else begin
            ph_cnt_q      <= ph_cnt_q + PH_W'(1);
            led_user_q    <= 1'b1;
          end
        end
        BL_OFF: begin
          if (ph_cnt_q == PULSE_LAST) begin
            ph_cnt_q <= '0;
            if (pulse_cnt_q == pulse_target_s) begin
              blink_state_q <= BL_GAP;
              led_user_q    <= 1'b0;
            end else begin
              blink_state_q <= BL_ON;
              led_user_q    <= 1'b1;
            end
          end else begin
            ph_cnt_q   <= ph_cnt_q + PH_W'(1);
            led_user_q <= 1'b0;
          end
        end
        default: begin
          blink_state_q <= BL_GAP;
          ph_cnt_q      <= '0;
          pulse_cnt_q   <= 3'd0;
          led_user_q    <= 1'b0;
        end
      endcase
    end
  end

  assign LED_BUS  = led_bus_q;
  assign MODE     = mode_q;
  assign LED_USER = led_user_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed testbench for led_mode_ctrl.
// Parameters: DEBOUNCE_CYCLES=4, STEP_CYCLES=3, PULSE_CYCLES=2.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at that same point.
module tb_led_mode_ctrl;

  localparam int DB = 4;
  localparam int ST = 3;
  localparam int PU = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] SW;
  logic       MODE_BTN;
  logic [3:0] LED_BUS;
  logic [1:0] MODE;
  logic       LED_USER;

  int n_tests = 0;
  int n_fail  = 0;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_CYCLES    (ST),
    .PULSE_CYCLES   (PU)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SW      (SW),
    .MODE_BTN(MODE_BTN),
    .LED_BUS (LED_BUS),
    .MODE    (MODE),
    .LED_USER(LED_USER)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Expected LED_USER level i cycles after MODE last changed, with n pulses per round.
  function automatic logic blink_exp(input int i, input int n);
    int k;
    k = i % (4 * PU + 2 * PU * n);
    if (k < 4 * PU) return 1'b0;
    return ((k - 4 * PU) % (2 * PU)) < PU;
  endfunction

  // Raise the button and wait, bounded, for MODE to change. Leaves the button high.
  task automatic press_mode(output bit ok);
    logic [1:0] start;
    start    = MODE;
    ok       = 1'b0;
    MODE_BTN = 1'b1;
    for (int i = 0; i < 12 && !ok; i++) begin
      step();
      if (MODE !== start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_led;
    RST = 1'b1; SW = 4'b0000; MODE_BTN = 1'b0;
    steps(3);
    n_tests++;
    if ({LED_BUS, MODE, LED_USER} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got LED_BUS=%b MODE=%0d LED_USER=%b, expected all 0", LED_BUS, MODE, LED_USER);
    end
    RST = 1'b0; SW = 4'b1011;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_led = (i >= 7) ? 4'b1011 : 4'b0000;
      n_tests++;
      if (LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL sw_latency c%0d: got %b, expected %b", i, LED_BUS, exp_led);
      end
      n_tests++;
      if (MODE !== 2'd0 || LED_USER !== (i == 8)) begin
        n_fail++;
        $display("FAIL post_reset_mode_user c%0d: got MODE=%0d USER=%b, expected MODE=0 USER=%b", i, MODE, LED_USER, (i == 8));
      end
    end
  endtask

  task automatic test_mode_step();
    logic [3:0] exp_led;
    logic [1:0] exp_mode;
    MODE_BTN = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      exp_mode = (i >= 7) ? 2'd1 : 2'd0;
      exp_led  = (i >= 7) ? 4'b1101 : 4'b1011;
      n_tests++;
      if (MODE !== exp_mode || LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL mode_step c%0d: got MODE=%0d LED=%b, expected MODE=%0d LED=%b", i, MODE, LED_BUS, exp_mode, exp_led);
      end
    end
    MODE_BTN = 1'b0;
    steps(10);
    n_tests++;
    if (MODE !== 2'd1) begin
      n_fail++;
      $display("FAIL mode_release: got %0d, expected 1", MODE);
    end
    SW = 4'b1111;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_led = (i == 7) ? 4'b1011 : 4'b1101;
      n_tests++;
      if (LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL mode1_sw1111 c%0d: got %b, expected %b", i, LED_BUS, exp_led);
      end
    end
    SW = 4'b0000;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_led = (i == 7) ? 4'b0000 : 4'b1011;
      n_tests++;
      if (LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL mode1_sw0000 c%0d: got %b, expected %b", i, LED_BUS, exp_led);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_led;
    logic [1:0] exp_mode;
    SW = 4'b0100; steps(3); SW = 4'b0000;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_tests++;
      if (LED_BUS !== 4'b0000) begin
        n_fail++;
        $display("FAIL sw_glitch3 c%0d: got %b, expected 0000", i, LED_BUS);
      end
    end
    MODE_BTN = 1'b1; steps(3); MODE_BTN = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      n_tests++;
      if (MODE !== 2'd1) begin
        n_fail++;
        $display("FAIL btn_glitch3 c%0d: got %0d, expected 1", i, MODE);
      end
    end
    SW = 4'b0100;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4) SW = 4'b0000;
      exp_led = (i >= 7 && i <= 10) ? 4'b0101 : 4'b0000;
      n_tests++;
      if (LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL sw_pulse4 c%0d: got %b, expected %b", i, LED_BUS, exp_led);
      end
    end
    MODE_BTN = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4) MODE_BTN = 1'b0;
      exp_mode = (i >= 7) ? 2'd2 : 2'd1;
      n_tests++;
      if (MODE !== exp_mode) begin
        n_fail++;
        $display("FAIL btn_pulse4 c%0d: got %0d, expected %0d", i, MODE, exp_mode);
      end
    end
  endtask

  task automatic test_chase();
    logic [3:0] exp_led;
    logic [3:0] cur;
    bit         found;
    SW = 4'b0001;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_led = (i == 7) ? 4'b1000 : 4'b0000;
      n_tests++;
      if (LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL mode2_reverse c%0d: got %b, expected %b", i, LED_BUS, exp_led);
      end
    end
    SW = 4'b0000;
    steps(8);
    MODE_BTN = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (i == 5) MODE_BTN = 1'b0;
      exp_led = (i >= 7) ? (4'b0001 << (((i - 7) / 3) % 4)) : 4'b0000;
      n_tests++;
      if (LED_BUS !== exp_led || MODE !== ((i >= 7) ? 2'd3 : 2'd2)) begin
        n_fail++;
        $display("FAIL chase_left c%0d: got LED=%b MODE=%0d, expected LED=%b", i, LED_BUS, MODE, exp_led);
      end
    end
    SW = 4'b0001;
    steps(8);
    cur = LED_BUS; found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      step();
      if (LED_BUS !== cur) found = 1'b1;
    end
    n_tests++;
    if (!found || LED_BUS !== {cur[0], cur[3:1]}) begin
      n_fail++;
      $display("FAIL chase_right_first: got %b (changed=%0d), expected %b", LED_BUS, found, {cur[0], cur[3:1]});
    end
    cur = LED_BUS;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_led = (i == 3) ? {cur[0], cur[3:1]} : cur;
      n_tests++;
      if (LED_BUS !== exp_led) begin
        n_fail++;
        $display("FAIL chase_right_period c%0d: got %b, expected %b", i, LED_BUS, exp_led);
      end
    end
    SW = 4'b0011;
    steps(8);
    cur = LED_BUS;
    n_tests++;
    if (!$onehot(cur)) begin
      n_fail++;
      $display("FAIL chase_onehot: got %b, expected one-hot", cur);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      n_tests++;
      if (LED_BUS !== cur) begin
        n_fail++;
        $display("FAIL chase_freeze c%0d: got %b, expected %b", i, LED_BUS, cur);
      end
    end
  endtask

  task automatic test_blink();
    bit ok;
    SW = 4'b0000;
    for (int p = 0; p < 2; p++) begin
      press_mode(ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL blink_setup_press%0d: got no MODE change, expected one", p);
      end
      MODE_BTN = 1'b0;
      steps(8);
    end
    press_mode(ok);
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) step();
      if (i == 1)  MODE_BTN = 1'b0;
      if (i == 26) MODE_BTN = 1'b1;
      if (i == 31) MODE_BTN = 1'b0;
      n_tests++;
      if (!ok || MODE !== 2'd2 || LED_USER !== blink_exp(i, 3)) begin
        n_fail++;
        $display("FAIL blink_mode2 c%0d: got MODE=%0d USER=%b, expected MODE=2 USER=%b", i, MODE, LED_USER, blink_exp(i, 3));
      end
    end
    for (int j = 0; j <= 31; j++) begin
      step();
      n_tests++;
      if (MODE !== 2'd3 || LED_USER !== blink_exp(j, 4)) begin
        n_fail++;
        $display("FAIL blink_mode3 c%0d: got MODE=%0d USER=%b, expected MODE=3 USER=%b", j, MODE, LED_USER, blink_exp(j, 4));
      end
    end
    press_mode(ok);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      if (i == 1) MODE_BTN = 1'b0;
      n_tests++;
      if (!ok || MODE !== 2'd0 || LED_USER !== blink_exp(i, 1)) begin
        n_fail++;
        $display("FAIL blink_wrap_mode0 c%0d: got MODE=%0d USER=%b, expected MODE=0 USER=%b", i, MODE, LED_USER, blink_exp(i, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit         ok;
    logic [3:0] exp_led;
    for (int p = 0; p < 2; p++) begin
      press_mode(ok);
      MODE_BTN = 1'b0;
      steps(8);
    end
    press_mode(ok);
    MODE_BTN = 1'b0;
    steps(7);
    SW = 4'b0110;
    steps(2);
    n_tests++;
    if (!ok || MODE !== 2'd3 || LED_BUS !== 4'b1000 || LED_USER !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got MODE=%0d LED=%b USER=%b, expected MODE=3 LED=1000 USER=1", MODE, LED_BUS, LED_USER);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_tests++;
    if ({LED_BUS, MODE, LED_USER} !== 7'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got LED=%b MODE=%0d USER=%b, expected all 0", LED_BUS, MODE, LED_USER);
    end
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_led = (i == 7) ? 4'b0110 : 4'b0000;
      n_tests++;
      if (LED_BUS !== exp_led || MODE !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_debounce_restart c%0d: got LED=%b MODE=%0d, expected LED=%b MODE=0", i, LED_BUS, MODE, exp_led);
      end
    end
  endtask

  initial begin
    RST = 1'b1; SW = 4'b0000; MODE_BTN = 1'b0;
    test_reset();
    test_mode_step();
    test_glitch();
    test_chase();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Sequencing controller for the 4-switch / 4-LED user I/O path on the 16 MHz board clock. It synchronizes and debounces the raw switch bus and a mode button. It cycles through four LED mapping modes and drives the registered LED_BUS for the selected mode. It also drives LED_USER with a blink code that shows the active mode.

Parameters:
DEBOUNCE_CYCLES, 16000, consecutive stable cycles before a debounced input changes (1 ms at 16 MHz); minimum 2
STEP_CYCLES, 4000000, cycles per chase step in mode 3 (250 ms); minimum 1
PULSE_CYCLES, 2000000, length of each blink-code on and off phase (125 ms); minimum 1

Ports:
CLK  input  1  16 MHz system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
SW  input  4  raw asynchronous switch inputs
MODE_BTN  input  1  raw asynchronous mode-advance button, active-high
LED_BUS  output  4  registered LED drive
MODE  output  2  current mode, registered
LED_USER  output  1  mode blink code, registered

Behaviour:
- Interface: single clock CLK; RST is synchronous and active-high.
- Reset values (RST sampled high): LED_BUS=0, MODE=0, LED_USER=0, all sync flops=0, debounced values=0, debounce counters=0, chase pattern=4'b0001, chase counter=0, blink FSM=GAP with counter=0 and pulse count=0. RST has priority over every other event, including a mode change in flight.
- Synchronizer: each of SW[3:0] and MODE_BTN passes through two flops.
- Debounce, per bit, 5 independent instances:
  - When the synced value equals the debounced value, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced value.
- Mode advance:
  - A rising edge of debounced MODE_BTN raises mode_step for one cycle.
  - MODE increments modulo 4 on the next edge (3 -> 0 wrap).
  - Holding the button gives exactly one step. The falling edge does nothing.
- Mapping, with d = debounced SW. LED_BUS registers the mapping 1 cycle after d changes.
  - Mode 0: LED_BUS = d.
  - Mode 1: LED_BUS = {d[3], ^d, &d, |d}, MSB first.
  - Mode 2: LED_BUS = bit-reverse of d.
  - Mode 3 (chase): LED_BUS = one-hot chase pattern.
- Chase, mode 3:
  - On entering mode 3, the pattern resets to 0001 and the counter to 0.
  - While d[1]=0, the counter counts to STEP_CYCLES-1, then wraps and steps the pattern.
  - d[0]=0 rotates left (0001 -> 0010 -> 0100 -> 1000 -> 0001). d[0]=1 rotates right.
  - d[1]=1 freezes both the counter and the pattern.
  - The pattern is always one-hot.
- Blink FSM (states GAP, ON, OFF; n = MODE+1 pulses):
  - GAP: LED_USER=0 for 4*PULSE_CYCLES cycles -> ON, pulse count=0.
  - ON: LED_USER=1 for PULSE_CYCLES cycles -> OFF, pulse count+1.
  - OFF: LED_USER=0 for PULSE_CYCLES cycles. If pulse count==n -> GAP, else -> ON.
  - Phase counter width covers 4*PULSE_CYCLES.
  - A MODE change forces GAP with counter=0 on the cycle MODE updates. The new code is never mixed with the old.
- Latency: a raw SW change held stable from cycle t appears on LED_BUS (modes 0-2) at cycle t+2+DEBOUNCE_CYCLES+1. This figure is fixed and checked by the bench.
- Simultaneous events: a mode step and a switch change in the same cycle: LED_BUS on the next cycle uses the new MODE with the current d.

Test Plan:
Use DEBOUNCE_CYCLES=4, STEP_CYCLES=3, PULSE_CYCLES=2 for all scenarios.
1. Reset, then SW=4'b1011 held -> LED_BUS=0 until exactly cycle t+7, then 1011. MODE=0, LED_USER=0 during the first 8 cycles after reset.
2. SW=1011, MODE_BTN held 20 cycles -> MODE steps once to 1, LED_BUS={1,1,0,1}=1101. SW=1111 -> 1011. SW=0000 -> 0000.
3. 3-cycle SW[2] glitch, and a 3-cycle MODE_BTN pulse -> no change on LED_BUS or MODE. A 4-cycle pulse -> change.
4. Step to mode 2, SW=0001 -> LED_BUS=1000. Step to mode 3 with SW=0000 -> 0001, 0010, 0100, 1000, 0001, changing every 3 cycles. SW[0]=1 -> sequence reverses. SW[1]=1 -> frozen for 20 cycles.
5. MODE=2: LED_USER runs 8 cycles low then 3 pulses (2 high, 2 low). A mode press mid-pulse -> LED_USER low and GAP restart on the MODE update cycle, then 4 pulses. MODE 3 -> 0 wraps to 1 pulse.
6. RST asserted mid-chase and mid-blink for 1 cycle -> next cycle all outputs 0, MODE=0. Debounce restarts: a SW change needs the full t+7 latency again.
